// File: rtl/tohost_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tohost_monitor_pkg
// Description : Shared types and constants for the tohost run monitor:
//               FSM state encoding (also exported on io_state), the tohost
//               done-bit position and the fail-code width.
// Revision    : 1.0 - initial release
// ============================================================================
package tohost_monitor_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_e;

  localparam int TOHOST_DONE_BIT = 0;
  localparam int FAIL_CODE_W     = 31;

  // Terminal states halt the tile and present a verdict.
  function automatic logic is_terminal(input state_e s);
    return (s == PASS) || (s == FAIL) || (s == TIMEOUT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear, count enable and an
//               optional saturate-at-all-ones mode (wraps when i_sat is 0).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] C_MAX = '1;
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // Clear has priority over counting; saturation blocks the increment at max.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !(i_sat && (r_count == C_MAX))) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tohost_monitor
// Description : Run controller and verdict monitor for the EECS151 tile.
//               Holds the tile in reset for RESET_HOLD_CYCLES, runs it while
//               watching the tohost word, and latches PASS / FAIL / TIMEOUT.
//               Build macro TOHOST_MONITOR_WATCHDOG_EN enables the TIMEOUT
//               transition; without it the run counter saturates and RUN
//               lasts until a tohost hit or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tohost_monitor
  import tohost_monitor_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 30,
  parameter int TIMEOUT_CYCLES    = 100,
  parameter int CYCLE_W           = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_rerun,
  input  logic [31:0]            io_tohost,
  output logic                   io_core_reset,
  output logic                   io_done,
  output logic                   io_passed,
  output logic                   io_failed,
  output logic                   io_timeout,
  output logic [FAIL_CODE_W-1:0] io_fail_code,
  output logic [CYCLE_W-1:0]     io_cycles,
  output logic [2:0]             io_state
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [HOLD_W-1:0]      w_hold_cnt;
  logic [CYCLE_W-1:0]     w_cycles;
  logic [FAIL_CODE_W-1:0] w_code;
  logic [FAIL_CODE_W-1:0] r_fail_code;
  logic                   w_hit;
  logic                   w_code_nz;
  logic                   w_terminal;
  logic                   w_rerun_go;
  logic                   w_timeout_hit;
  logic                   w_run_sat;

  assign w_hit      = io_tohost[TOHOST_DONE_BIT];
  assign w_code     = io_tohost[31:1];
  assign w_code_nz  = |w_code;
  assign w_terminal = is_terminal(r_state);
  assign w_rerun_go = w_terminal && io_rerun;

`ifdef TOHOST_MONITOR_WATCHDOG_EN
  localparam logic [CYCLE_W:0] C_TIMEOUT  = (CYCLE_W + 1)'(TIMEOUT_CYCLES);
  localparam logic [CYCLE_W:0] C_INC_EXT  = (CYCLE_W + 1)'(1);

  // Threshold is judged on the post-increment count of this RUN cycle.
  assign w_timeout_hit = (({1'b0, w_cycles} + C_INC_EXT) == C_TIMEOUT);
  assign w_run_sat     = 1'b0;
`else
  logic w_unused_timeout;

  // The threshold has no effect without the watchdog; keep it referenced.
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout_hit    = 1'b0;
  assign w_run_sat        = 1'b1;
`endif

  // Hold counter: zero outside HOLD so every entry into HOLD restarts it.
  sat_counter #(
    .WIDTH (HOLD_W)
  ) u_hold_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_clr   (r_state != HOLD),
    .i_en    (r_state == HOLD),
    .i_sat   (1'b1),
    .o_count (w_hold_cnt)
  );

  // Run-cycle counter: counts hit-free RUN cycles, frozen in terminal states.
  sat_counter #(
    .WIDTH (CYCLE_W)
  ) u_run_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_clr   ((r_state == HOLD) || w_rerun_go),
    .i_en    ((r_state == RUN) && !w_hit),
    .i_sat   (w_run_sat),
    .o_count (w_cycles)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a tohost hit outranks the timeout threshold.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      HOLD: begin
        if (w_hold_cnt == C_HOLD_LAST) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_hit) begin
          w_state_next = w_code_nz ? FAIL : PASS;
        end else if (w_timeout_hit) begin
          w_state_next = TIMEOUT;
        end
      end
      PASS, FAIL, TIMEOUT: begin
        if (io_rerun) begin
          w_state_next = HOLD;
        end
      end
      default: w_state_next = HOLD;
    endcase
  end

  // Fail code latches on a failing hit and clears on rerun.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fail_code <= '0;
    end else if ((r_state == RUN) && w_hit && w_code_nz) begin
      r_fail_code <= w_code;
    end else if (w_rerun_go) begin
      r_fail_code <= '0;
    end
  end

  // Outputs decode registered state only, so no input reaches them directly.
  always_comb begin
    io_core_reset = (r_state != RUN);
    io_done       = w_terminal;
    io_passed     = (r_state == PASS);
    io_failed     = (r_state == FAIL);
`ifdef TOHOST_MONITOR_WATCHDOG_EN
    io_timeout    = (r_state == TIMEOUT);
`else
    io_timeout    = 1'b0;
`endif
    io_fail_code  = r_fail_code;
    io_cycles     = w_cycles;
    io_state      = r_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_tohost_monitor
// Description : Directed self-checking bench for tohost_monitor with
//               RESET_HOLD_CYCLES=4, TIMEOUT_CYCLES=20, plus a 4-bit-counter
//               instance for the saturation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tohost_monitor;

  localparam int H = 4;
  localparam int T = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_rerun;
  logic [31:0] io_tohost;
  logic        io_core_reset, io_done, io_passed, io_failed, io_timeout;
  logic [30:0] io_fail_code;
  logic [31:0] io_cycles;
  logic [2:0]  io_state;

  logic        s_reset;
  logic        s_rerun;
  logic [31:0] s_tohost;
  logic        s_core_reset, s_done, s_passed, s_failed, s_timeout;
  logic [30:0] s_fail_code;
  logic [3:0]  s_cycles;
  logic [2:0]  s_state;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tohost_monitor #(
    .RESET_HOLD_CYCLES (H),
    .TIMEOUT_CYCLES    (T),
    .CYCLE_W           (32)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .io_rerun      (io_rerun),
    .io_tohost     (io_tohost),
    .io_core_reset (io_core_reset),
    .io_done       (io_done),
    .io_passed     (io_passed),
    .io_failed     (io_failed),
    .io_timeout    (io_timeout),
    .io_fail_code  (io_fail_code),
    .io_cycles     (io_cycles),
    .io_state      (io_state)
  );

  tohost_monitor #(
    .RESET_HOLD_CYCLES (H),
    .TIMEOUT_CYCLES    (T),
    .CYCLE_W           (4)
  ) u_dut_sat (
    .clock         (clock),
    .reset         (s_reset),
    .io_rerun      (s_rerun),
    .io_tohost     (s_tohost),
    .io_core_reset (s_core_reset),
    .io_done       (s_done),
    .io_passed     (s_passed),
    .io_failed     (s_failed),
    .io_timeout    (s_timeout),
    .io_fail_code  (s_fail_code),
    .io_cycles     (s_cycles),
    .io_state      (s_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_status(input string tag, input int st, input bit core_rst,
                               input bit done, input bit p, input bit f, input bit t,
                               input int cyc, input int code);
    check({tag, ".state"},      64'(io_state),      64'(st));
    check({tag, ".core_reset"}, 64'(io_core_reset), 64'(core_rst));
    check({tag, ".done"},       64'(io_done),       64'(done));
    check({tag, ".passed"},     64'(io_passed),     64'(p));
    check({tag, ".failed"},     64'(io_failed),     64'(f));
    check({tag, ".timeout"},    64'(io_timeout),    64'(t));
    check({tag, ".cycles"},     64'(io_cycles),     64'(cyc));
    check({tag, ".fail_code"},  64'(io_fail_code),  64'(code));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    io_rerun  = 1'b0;
    io_tohost = 32'h0;
    s_reset   = 1'b1;
    s_rerun   = 1'b0;
    s_tohost  = 32'h0;
    step(2);
    expect_status("reset", 0, 1, 0, 0, 0, 0, 0, 0);

    // Release reset; HOLD lasts four cycles.
    reset   = 1'b0;
    s_reset = 1'b0;
    step(3);
    expect_status("hold3", 0, 1, 0, 0, 0, 0, 0, 0);
    step(1);
    expect_status("run_entry", 1, 0, 0, 0, 0, 0, 0, 0);

    // Pass on the third RUN cycle.
    step(1);
    check("run_c1", 64'(io_cycles), 64'd1);
    step(1);
    check("run_c2", 64'(io_cycles), 64'd2);
    io_tohost = 32'h1;
    step(1);
    expect_status("pass_t1", 2, 1, 1, 1, 0, 0, 2, 0);
    io_tohost = 32'h0;
    step(2);
    expect_status("pass_hold", 2, 1, 1, 1, 0, 0, 2, 0);

    // Rerun from PASS; a hit during HOLD must be ignored.
    io_rerun  = 1'b1;
    io_tohost = 32'h1;
    step(1);
    io_rerun = 1'b0;
    expect_status("rerun", 0, 1, 0, 0, 0, 0, 0, 0);
    step(3);
    expect_status("hold_tohost", 0, 1, 0, 0, 0, 0, 0, 0);
    io_tohost = 32'hFFFF_FFFE;
    step(1);
    expect_status("run2", 1, 0, 0, 0, 0, 0, 0, 0);
    io_rerun = 1'b1;
    step(1);
    io_rerun = 1'b0;
    expect_status("rerun_in_run", 1, 0, 0, 0, 0, 0, 1, 0);
    step(2);
    expect_status("even_ignored", 1, 0, 0, 0, 0, 0, 3, 0);
    io_tohost = 32'h1;
    step(1);
    expect_status("pass_t4", 2, 1, 1, 1, 0, 0, 3, 0);

    // Fail with test number 5 on the first RUN cycle.
    io_rerun  = 1'b1;
    io_tohost = 32'h0;
    step(1);
    io_rerun = 1'b0;
    step(4);
    expect_status("run3", 1, 0, 0, 0, 0, 0, 0, 0);
    io_tohost = 32'h0000_000B;
    step(1);
    expect_status("fail", 3, 1, 1, 0, 1, 0, 0, 5);
    io_tohost = 32'h1;
    step(2);
    expect_status("fail_hold", 3, 1, 1, 0, 1, 0, 0, 5);
    io_rerun  = 1'b1;
    io_tohost = 32'h0;
    step(1);
    io_rerun = 1'b0;
    expect_status("rerun_fail", 0, 1, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of RUN.
    step(4);
    expect_status("run4", 1, 0, 0, 0, 0, 0, 0, 0);
    step(7);
    expect_status("run7", 1, 0, 0, 0, 0, 0, 7, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_status("reset_mid_run", 0, 1, 0, 0, 0, 0, 0, 0);
    step(4);
    expect_status("run5", 1, 0, 0, 0, 0, 0, 0, 0);

`ifdef TOHOST_MONITOR_WATCHDOG_EN
    // Timeout after the 20th hit-free RUN cycle.
    step(19);
    expect_status("pre_timeout", 1, 0, 0, 0, 0, 0, 19, 0);
    step(1);
    expect_status("timeout", 4, 1, 1, 0, 0, 1, 20, 0);
    io_rerun = 1'b1;
    step(1);
    io_rerun = 1'b0;
    expect_status("rerun_timeout", 0, 1, 0, 0, 0, 0, 0, 0);
    step(4);
    step(19);
    expect_status("pre_timeout2", 1, 0, 0, 0, 0, 0, 19, 0);
    io_tohost = 32'h1;
    step(1);
    expect_status("hit_beats_timeout", 2, 1, 1, 1, 0, 0, 19, 0);
    io_tohost = 32'h0;
`else
    // Without the watchdog RUN continues past the threshold.
    step(25);
    expect_status("no_watchdog", 1, 0, 0, 0, 0, 0, 25, 0);
    io_tohost = 32'h1;
    step(1);
    expect_status("late_pass", 2, 1, 1, 1, 0, 0, 25, 0);
    io_tohost = 32'h0;
    // The 4-bit instance has run far beyond 15 hit-free cycles.
    check("sat.cycles",  64'(s_cycles),  64'd15);
    check("sat.state",   64'(s_state),   64'd1);
    check("sat.timeout", 64'(s_timeout), 64'd0);
    check("sat.done",    64'(s_done),    64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tohost_monitor.md
# tohost_monitor

Synthesizable run controller and result monitor that wraps the EECS151 tile for on-board and simulation ISA regression. It sequences the tile's reset, counts execution cycles, watches the tile's `io_debug_syscall0` (tohost) word, and latches pass, fail or timeout status. It sits directly downstream of the tile's debug syscall output and upstream of the tile's `reset` input. A bench or board wrapper can read a final verdict without peeking into hierarchy.

## Interface
Parameters:
- `RESET_HOLD_CYCLES`, 30: cycles the tile reset stays asserted after monitor reset or rerun; must be ≥ 1.
- `TIMEOUT_CYCLES`, 100: number of RUN cycles without a tohost hit before a timeout is declared; must be ≥ 1.
- `CYCLE_W`, 32: width of the run-cycle counter.

Ports:
- `clock`  in  1: single clock; everything is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `io_rerun`  in  1: single-cycle pulse that restarts the sequence from HOLD. It is honoured only in a terminal state.
- `io_tohost`  in  32: the tile's `io_debug_syscall0`.
- `io_core_reset`  out  1: drives the tile's `reset`.
- `io_done`  out  1: high in any terminal state.
- `io_passed` / `io_failed` / `io_timeout`  out  1 each: one-hot verdict, valid while `io_done` is high.
- `io_fail_code`  out  31: latched `io_tohost[31:1]` on fail; otherwise 0.
- `io_cycles`  out  CYCLE_W: run-cycle count, live during RUN and frozen in terminal states.
- `io_state`  out  3: current FSM state encoding, for debug.

## Operation
States: HOLD, RUN, PASS, FAIL, TIMEOUT.

- **HOLD**: `io_core_reset`=1. The hold counter counts 0..RESET_HOLD_CYCLES-1, then the FSM goes to RUN. `io_cycles` is cleared to 0.
- **RUN**: `io_core_reset`=0. `io_tohost` is sampled every cycle.
  - If `io_tohost[0]`=1 and `io_tohost[31:1]`=0, go to PASS.
  - If `io_tohost[0]`=1 and `io_tohost[31:1]`≠0, go to FAIL and latch `io_fail_code` ← `io_tohost[31:1]`.
  - Otherwise `io_cycles` increments. If the post-increment value equals TIMEOUT_CYCLES, go to TIMEOUT.
- **PASS / FAIL / TIMEOUT**: terminal states.
  - `io_core_reset`=1, so the tile is halted.
  - `io_done`=1 and the matching verdict bit is 1.
  - Every output holds until `reset` or `io_rerun`.
  - `io_rerun` goes to HOLD, clears the verdict, `io_fail_code` and `io_cycles`, and restarts the hold count.

Counter arithmetic and boundary behaviour:
- `io_cycles` counts RUN cycles that did not see a tohost hit. A hit on the first RUN cycle yields `io_cycles`=0.
- A hit and the timeout threshold in the same cycle: the hit wins, and PASS or FAIL is taken.
- `io_tohost` bits with `[0]`=0 are ignored, regardless of `[31:1]`.
- `io_rerun` in HOLD or RUN is ignored.
- `io_tohost` is never sampled in HOLD, so values driven while the tile is in reset cannot produce a verdict.

## Timing
- Reset values: state=HOLD, `io_core_reset`=1, and all other outputs 0.
- `reset` asserted in any state forces the FSM back to HOLD on the next edge. This includes mid-RUN.
- With `reset` deasserted at edge 0, `io_core_reset` falls after edge RESET_HOLD_CYCLES.
- Verdict latency: the verdict outputs are registered. They rise one cycle after the RUN cycle that sampled the hit or reached the timeout.
- All outputs are registered. There are no combinational paths from `io_tohost` or `io_rerun` to any output.

## Configuration
`TOHOST_MONITOR_WATCHDOG_EN`:
- **Defined**: the TIMEOUT transition exists as described above.
- **Undefined**: the TIMEOUT state is unreachable and `io_timeout` is tied to 0. `io_cycles` saturates at all-ones rather than wrapping. RUN persists until a tohost hit, `reset`, or forever.

## Structure
- `tohost_monitor_pkg` holds:
  - the `state_e` enum: HOLD=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, matching the `io_state` encoding;
  - the `TOHOST_DONE_BIT`=0 constant;
  - the fail-code width constant (31).
- One sub-module, `sat_counter` (parameterized width, synchronous clear, enable, saturate flag). It is instantiated for the hold counter and for the run-cycle counter.

## Test plan
Use RESET_HOLD_CYCLES=4 and TIMEOUT_CYCLES=20 unless noted.

1. Release `reset`, drive `io_tohost`=0x00000001 on the 3rd RUN cycle.
   - Expect `io_core_reset` low after 4 hold cycles.
   - Then `io_passed`=1, `io_done`=1, `io_cycles`=2 one cycle later.
2. Drive `io_tohost`=0x0000000B (test 5 failed).
   - Expect `io_failed`=1 and `io_fail_code`=5, with `io_core_reset` reasserted.
3. Hold `io_tohost`=0 with the watchdog enabled.
   - Expect `io_timeout`=1 and `io_cycles`=20 after the 20th RUN cycle.
   - Drive 0x1 on that same 20th cycle instead: expect PASS, not TIMEOUT.
4. Drive `io_tohost`=0xFFFFFFFE throughout RUN, then 0x1.
   - The first value gives no verdict; the second gives PASS.
   - Drive 0x1 during HOLD: no verdict.
5. After PASS, pulse `io_rerun`.
   - Expect HOLD, `io_cycles`=0, verdict cleared, 4 hold cycles, then RUN.
   - Pulse `io_rerun` during RUN: no effect.
6. Assert `reset` mid-RUN at `io_cycles`=7.
   - Expect state=HOLD, `io_core_reset`=1, `io_cycles`=0 after the next edge.
   - Build without `TOHOST_MONITOR_WATCHDOG_EN`, CYCLE_W=4: `io_cycles` saturates at 15 and no timeout occurs.
